// File: rtl/reg_wb_pkg.sv
// +-----------------------------------------------------------------------------
// | Module      : reg_wb_pkg
// | Description : Shared types and constants for the writeback arbiter.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

package reg_wb_pkg;

  localparam int NUM_WB_SRC = 3;

  // Values match the writeback mux select so wb_sel can drive it directly
  typedef enum logic [1:0] {
    WB_PC  = 2'b00,
    WB_ALU = 2'b01,
    WB_MEM = 2'b10
  } wb_sel_e;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_e;

  // Request/grant bit positions, also the round-robin search order
  localparam logic [1:0] SRC_MEM = 2'd0;
  localparam logic [1:0] SRC_ALU = 2'd1;
  localparam logic [1:0] SRC_PC  = 2'd2;

  function automatic logic [1:0] src_wrap(input logic [2:0] s);
    logic [2:0] r;
    r = (s >= 3'd3) ? (s - 3'd3) : s;
    return r[1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_wb_pick.sv
// +-----------------------------------------------------------------------------
// | Module      : reg_wb_pick
// | Description : One-hot grant picker; fixed MEM > ALU > PC, or round-robin
// |               starting at ptr when REG_WB_RR_EN is defined.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module reg_wb_pick
  import reg_wb_pkg::*;
(
  input  logic [NUM_WB_SRC-1:0] req,
  input  logic [1:0]            ptr,
  output logic [NUM_WB_SRC-1:0] gnt
);

`ifdef REG_WB_RR_EN
  always_comb begin
    logic       w_found;
    logic [1:0] w_idx;
    gnt     = '0;
    w_found = 1'b0;
    w_idx   = 2'd0;
    for (int k = 0; k < NUM_WB_SRC; k++) begin
      w_idx = src_wrap({1'b0, ptr} + 3'(k));
      if (!w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end
`else
  logic w_unused_ptr;
  assign w_unused_ptr = ^ptr;

  assign gnt[SRC_MEM] = req[SRC_MEM];
  assign gnt[SRC_ALU] = req[SRC_ALU] & ~req[SRC_MEM];
  assign gnt[SRC_PC]  = req[SRC_PC]  & ~req[SRC_ALU] & ~req[SRC_MEM];
`endif

endmodule

`default_nettype wire

// File: rtl/reg_wb_arbiter.sv
// +-----------------------------------------------------------------------------
// | Module      : reg_wb_arbiter
// | Description : Arbitrates PC/ALU/MEM writebacks into a one-entry output slot
// |               feeding the register file. REG_WB_RR_EN selects round-robin.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module reg_wb_arbiter
  import reg_wb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pc_valid,
  input  logic                      alu_valid,
  input  logic                      mem_valid,
  input  logic [REG_ADDR_WIDTH-1:0] pc_rd,
  input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0]     pc_data,
  input  logic [DATA_WIDTH-1:0]     alu_data,
  input  logic [DATA_WIDTH-1:0]     mem_data,
  output logic                      pc_ready,
  output logic                      alu_ready,
  output logic                      mem_ready,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]     rf_wdata,
  output logic [1:0]                wb_sel,
  input  logic                      rf_ready
);

  slot_state_e               r_state;
  logic [REG_ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0]     r_wdata;
  wb_sel_e                   r_sel;

  logic [NUM_WB_SRC-1:0]     w_req;
  logic [NUM_WB_SRC-1:0]     w_pick;
  logic [NUM_WB_SRC-1:0]     w_gnt;
  logic                      w_open;
  logic                      w_xfer;
  logic [1:0]                w_ptr;
  logic [1:0]                w_src;
  logic [REG_ADDR_WIDTH-1:0] w_rd;
  logic [DATA_WIDTH-1:0]     w_data;
  wb_sel_e                   w_sel;

  assign w_req[SRC_MEM] = mem_valid;
  assign w_req[SRC_ALU] = alu_valid;
  assign w_req[SRC_PC]  = pc_valid;

  reg_wb_pick u_pick (
    .req (w_req),
    .ptr (w_ptr),
    .gnt (w_pick)
  );

  // Slot can take a new entry when empty or when its current entry retires now
  assign w_open = !rst && ((r_state == ST_EMPTY) || rf_ready);
  assign w_gnt  = w_open ? w_pick : '0;
  assign w_xfer = |w_gnt;

  assign mem_ready = w_gnt[SRC_MEM];
  assign alu_ready = w_gnt[SRC_ALU];
  assign pc_ready  = w_gnt[SRC_PC];

  always_comb begin
    w_src  = SRC_MEM;
    w_rd   = mem_rd;
    w_data = mem_data;
    w_sel  = WB_MEM;
    if (w_gnt[SRC_ALU]) begin
      w_src  = SRC_ALU;
      w_rd   = alu_rd;
      w_data = alu_data;
      w_sel  = WB_ALU;
    end else if (w_gnt[SRC_PC]) begin
      w_src  = SRC_PC;
      w_rd   = pc_rd;
      w_data = pc_data;
      w_sel  = WB_PC;
    end
  end

`ifdef REG_WB_RR_EN
  logic [1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= SRC_MEM;
    end else if (w_xfer) begin
      r_ptr <= src_wrap({1'b0, w_src} + 3'd1);
    end
  end

  assign w_ptr = r_ptr;
`else
  logic w_unused_src;
  assign w_unused_src = ^w_src;
  assign w_ptr        = SRC_MEM;
`endif

  // Writes to x0 are consumed without occupying the slot
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_waddr <= '0;
      r_wdata <= '0;
      r_sel   <= WB_PC;
    end else if (w_xfer) begin
      if (w_rd != '0) begin
        r_state <= ST_FULL;
        r_waddr <= w_rd;
        r_wdata <= w_data;
        r_sel   <= w_sel;
      end else begin
        r_state <= ST_EMPTY;
      end
    end else if ((r_state == ST_FULL) && rf_ready) begin
      r_state <= ST_EMPTY;
    end
  end

  assign rf_we    = (r_state == ST_FULL);
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;
  assign wb_sel   = r_sel;

endmodule

`default_nettype wire

// File: tb/tb_reg_wb_arbiter.sv
// +-----------------------------------------------------------------------------
// | Module      : tb_reg_wb_arbiter
// | Description : Self-checking bench for reg_wb_arbiter against a slot model.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_reg_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic          pc_valid, alu_valid, mem_valid;
  logic [AW-1:0] pc_rd, alu_rd, mem_rd;
  logic [DW-1:0] pc_data, alu_data, mem_data;
  logic          pc_ready, alu_ready, mem_ready;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [1:0]    wb_sel;
  logic          rf_ready;

  int n_checks;
  int n_errors;

  // Reference model: slot contents and round-robin position (0=MEM,1=ALU,2=PC)
  bit            m_full;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [1:0]    m_sel;
  int            m_ptr;

  reg_wb_arbiter #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_valid  (pc_valid),
    .alu_valid (alu_valid),
    .mem_valid (mem_valid),
    .pc_rd     (pc_rd),
    .alu_rd    (alu_rd),
    .mem_rd    (mem_rd),
    .pc_data   (pc_data),
    .alu_data  (alu_data),
    .mem_data  (mem_data),
    .pc_ready  (pc_ready),
    .alu_ready (alu_ready),
    .mem_ready (mem_ready),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .wb_sel    (wb_sel),
    .rf_ready  (rf_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int winner();
    bit v[3];
    v[0] = mem_valid;
    v[1] = alu_valid;
    v[2] = pc_valid;
    if (rst || (m_full && !rf_ready)) return -1;
`ifdef REG_WB_RR_EN
    for (int k = 0; k < 3; k++)
      if (v[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
`else
    for (int k = 0; k < 3; k++)
      if (v[k]) return k;
`endif
    return -1;
  endfunction

  // Inputs are already applied; check readies, take the edge, check the slot
  task automatic tick();
    int            w;
    logic [AW-1:0] rd;
    logic [DW-1:0] d;
    #1;
    w = winner();
    chk("mem_ready", 64'(mem_ready), 64'(w == 0));
    chk("alu_ready", 64'(alu_ready), 64'(w == 1));
    chk("pc_ready",  64'(pc_ready),  64'(w == 2));
    @(posedge clk);
    if (rst) begin
      m_full = 0; m_addr = '0; m_data = '0; m_sel = 2'b00; m_ptr = 0;
    end else if (w >= 0) begin
      rd = (w == 0) ? mem_rd   : (w == 1) ? alu_rd   : pc_rd;
      d  = (w == 0) ? mem_data : (w == 1) ? alu_data : pc_data;
      m_ptr = (w + 1) % 3;
      if (rd != 0) begin
        m_full = 1; m_addr = rd; m_data = d;
        m_sel  = (w == 0) ? 2'b10 : (w == 1) ? 2'b01 : 2'b00;
      end else begin
        m_full = 0;
      end
    end else if (m_full && rf_ready) begin
      m_full = 0;
    end
    #1;
    chk("rf_we",    64'(rf_we),    64'(m_full));
    chk("rf_waddr", 64'(rf_waddr), 64'(m_addr));
    chk("rf_wdata", 64'(rf_wdata), 64'(m_data));
    chk("wb_sel",   64'(wb_sel),   64'(m_sel));
  endtask

  task automatic drive(input logic r, input logic rr,
                       input logic mv, input logic [AW-1:0] mrd, input logic [DW-1:0] md,
                       input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                       input logic pv, input logic [AW-1:0] prd, input logic [DW-1:0] pd);
    @(negedge clk);
    rst = r; rf_ready = rr;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    pc_valid  = pv; pc_rd  = prd; pc_data  = pd;
    tick();
  endtask

  function automatic logic [AW-1:0] rand_rd();
    return ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom_range(1, 31));
  endfunction

  initial begin
    n_checks = 0; n_errors = 0;
    m_full = 0; m_addr = '0; m_data = '0; m_sel = 2'b00; m_ptr = 0;
    rst = 1'b1; rf_ready = 1'b0;
    mem_valid = 0; alu_valid = 0; pc_valid = 0;
    mem_rd = '0; alu_rd = '0; pc_rd = '0;
    mem_data = '0; alu_data = '0; pc_data = '0;

    // Reset with every requester valid: no readies, slot cleared
    repeat (2) drive(1, 1, 1, 5'd7, 32'hAAAA0001, 1, 5'd8, 32'hAAAA0002, 1, 5'd9, 32'hAAAA0003);
    drive(0, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

    // MEM and ALU together: MEM first, ALU on the following cycle
    drive(0, 1, 1, 5'd5, 32'hDEADBEEF, 1, 5'd3, 32'h00000011, 0, 5'd0, 32'h0);
    drive(0, 1, 0, 5'd0, 32'h0,        1, 5'd3, 32'h00000011, 0, 5'd0, 32'h0);
    drive(0, 1, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 32'h0);

    // Write to x0 is swallowed
    drive(0, 1, 0, 5'd0, 32'h0, 1, 5'd0, 32'h00001234, 0, 5'd0, 32'h0);
    drive(0, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0);

    // PC link write stalled three cycles by the register file
    drive(0, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd1, 32'h80000004);
    repeat (3) drive(0, 0, 1, 5'd4, 32'h44, 1, 5'd6, 32'h66, 0, 5'd0, 32'h0);
    drive(0, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

    // Continuous ALU stream, one write per cycle
    for (int i = 0; i < 6; i++)
      drive(0, 1, 0, 5'd0, 32'h0, 1, AW'(10 + i), 32'hC0DE0000 + DW'(i), 0, 5'd0, 32'h0);

    // All requesters held: fixed priority or MEM/ALU/PC rotation after reset
    drive(1, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    for (int i = 0; i < 6; i++)
      drive(0, 1, 1, 5'd20, 32'hE0 + DW'(i), 1, 5'd21, 32'hA0 + DW'(i), 1, 5'd22, 32'h90 + DW'(i));

    // Randomized traffic including drops, stalls and reset pulses
    for (int i = 0; i < 600; i++)
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
            $urandom_range(0, 1), rand_rd(), $urandom,
            $urandom_range(0, 1), rand_rd(), $urandom,
            $urandom_range(0, 1), rand_rd(), $urandom);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
